// File: rtl/concat_pkg.sv
// concat_pkg: shared constants, helpers and types for the concat_packer slice.
//   DEF_IN_W / DEF_N_FIELDS : default field width and fields per word
//   cnt_width()             : counter width able to hold 0..N_FIELDS
//   out_state_e             : output holding-register state
package concat_pkg;

  localparam int unsigned DEF_IN_W     = 2;
  localparam int unsigned DEF_N_FIELDS = 3;

  // Counter must represent N_FIELDS itself (out_cnt of a full word).
  function automatic int unsigned cnt_width(input int unsigned n_fields);
    return $clog2(n_fields + 1);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/concat_out_reg.sv
// concat_out_reg: single-entry valid/ready holding register for packed words.
// Optional feature macro: CONCAT_PACKER_PARITY_EN (adds parity_o).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   load_i        : capture a new word this cycle (closing accept)
//   data_i/cnt_i/last_i : word payload to capture
//   ready_i       : downstream accepts the held word
//   valid_o       : a word is held
//   data_o/cnt_o/last_o : held payload (retained after drain)
//   parity_o      : XOR of data_o (only with CONCAT_PACKER_PARITY_EN)
module concat_out_reg
  import concat_pkg::*;
#(
  parameter int unsigned OUT_W = DEF_IN_W * DEF_N_FIELDS,
  parameter int unsigned CNT_W = cnt_width(DEF_N_FIELDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [OUT_W-1:0] data_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] data_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
`ifdef CONCAT_PACKER_PARITY_EN
  ,
  output logic             parity_o
`endif
);

  out_state_e       state_q, state_d;
  logic [OUT_W-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a load always wins, a drain without reload empties
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (load_i) state_d = FULL;
      end
      FULL: begin
        if (load_i)       state_d = FULL;
        else if (ready_i) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Payload registers only change on load, so they hold after drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      cnt_q  <= cnt_i;
      last_q <= last_i;
    end
  end

`ifdef CONCAT_PACKER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load_i) begin
      parity_q <= ^data_i;
    end
  end

  assign parity_o = parity_q;
`endif

  assign valid_o = (state_q == FULL);
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;
  assign last_o  = last_q;

endmodule

// File: rtl/concat_packer.sv
// concat_packer: packs N_FIELDS consecutive IN_W-bit fields into one word,
// first-accepted field in the MSBs; in_last flushes a partial word early.
// Optional feature macro: CONCAT_PACKER_PARITY_EN (adds out_parity).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : field stream handshake (in_ready combinational)
//   in_data, in_last      : field value, closes the current word
//   out_valid/out_ready   : packed word handshake
//   out_data              : {f0, f1, ..., f(N-1)}, unused LSB slots zero
//   out_cnt               : number of valid fields in out_data
//   out_last              : word was closed by in_last
//   out_parity            : XOR of out_data (only with CONCAT_PACKER_PARITY_EN)
module concat_packer
  import concat_pkg::*;
#(
  parameter  int unsigned IN_W     = DEF_IN_W,
  parameter  int unsigned N_FIELDS = DEF_N_FIELDS,
  localparam int unsigned OUT_W    = IN_W * N_FIELDS,
  localparam int unsigned CNT_W    = cnt_width(N_FIELDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_last
`ifdef CONCAT_PACKER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic [OUT_W-1:0] acc_q, acc_d, acc_ins;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             closing;

  // Independent of field position so upstream sees a simple stall rule
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign closing  = accept && ((cnt_q == CNT_W'(N_FIELDS - 1)) || in_last);

  // Slot insertion: slot s occupies bits [OUT_W-1-s*IN_W -: IN_W].
  // Later slots are still zero since acc is cleared on every close.
  always_comb begin
    acc_ins = acc_q;
    for (int unsigned s = 0; s < N_FIELDS; s++) begin
      if (cnt_q == CNT_W'(s)) acc_ins[OUT_W-1-s*IN_W -: IN_W] = in_data;
    end
  end

  // Accumulator / counter next state
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (closing) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = acc_ins;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  concat_out_reg #(
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (closing),
    .data_i   (acc_ins),
    .cnt_i    (cnt_q + CNT_W'(1)),
    .last_i   (in_last),
    .ready_i  (out_ready),
    .valid_o  (out_valid),
    .data_o   (out_data),
    .cnt_o    (out_cnt),
    .last_o   (out_last)
`ifdef CONCAT_PACKER_PARITY_EN
    ,
    .parity_o (out_parity)
`endif
  );

endmodule

// File: tb/tb_concat_packer.sv
// Testbench for concat_packer with a queue-based reference model.
module tb_concat_packer;

  localparam int unsigned IN_W  = 2;
  localparam int unsigned N     = 3;
  localparam int unsigned OUT_W = IN_W * N;
  localparam int unsigned CNT_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;
  logic             out_last;
`ifdef CONCAT_PACKER_PARITY_EN
  logic             out_parity;
`endif

  concat_packer #(.IN_W(IN_W), .N_FIELDS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_last  (out_last)
`ifdef CONCAT_PACKER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending fields plus the word currently presented
  int unsigned      fields[$];
  bit               m_valid;
  logic [OUT_W-1:0] m_data;
  int unsigned      m_cnt;
  bit               m_last;

  function automatic void model_reset();
    fields.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_cnt   = 0;
    m_last  = 1'b0;
  endfunction

  function automatic void model_step(input bit v, input int unsigned d, input bit l, input bit r);
    bit          ready;
    int unsigned word;
    ready = !m_valid || r;
    if (r) m_valid = 1'b0;
    if (v && ready) begin
      fields.push_back(d);
      if (fields.size() == N || l) begin
        word = 0;
        foreach (fields[i]) word += fields[i] * (1 << (IN_W * (N - 1 - i)));
        m_data  = OUT_W'(word);
        m_cnt   = fields.size();
        m_last  = l;
        m_valid = 1'b1;
        fields.delete();
      end
    end
  endfunction

  // One clock cycle of stimulus; returns in_ready observed and expected before the edge
  task automatic drive_cycle(input bit v, input int unsigned d, input bit l, input bit r,
                             output logic obs_rdy, output bit exp_rdy);
    in_valid  = v;
    in_data   = IN_W'(d);
    in_last   = l;
    out_ready = r;
    #1;
    obs_rdy = in_ready;
    exp_rdy = !m_valid || r;
    @(posedge clk);
    #1;
    model_step(v, d, l, r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_cnt !== '0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset: valid=%b data=%b cnt=%0d last=%b in_ready=%b, required 0 000000 0 0 1",
               out_valid, out_data, out_cnt, out_last, in_ready);
    end
`ifdef CONCAT_PACKER_PARITY_EN
    n_vec++;
    if (out_parity !== 1'b0) begin
      n_err++;
      $display("FAIL reset_parity: got %b required 0", out_parity);
    end
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Directed words from the plan, each checked against a hand-computed constant
  task automatic test_directed();
    logic o; bit e;
    // 01,10,11 -> 011011
    drive_cycle(1, 1, 0, 1, o, e);
    drive_cycle(1, 2, 0, 1, o, e);
    drive_cycle(1, 3, 0, 1, o, e);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 6'b011011 || out_cnt !== 2'd3 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL full_word: valid=%b data=%b cnt=%0d last=%b, required 1 011011 3 0",
               out_valid, out_data, out_cnt, out_last);
    end
    drive_cycle(0, 0, 0, 1, o, e);
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 6'b011011) begin
      n_err++;
      $display("FAIL one_cycle_valid: valid=%b data=%b, required 0 011011 (retained)", out_valid, out_data);
    end
    // 10 with in_last at cnt=0 -> 100000
    drive_cycle(1, 2, 1, 1, o, e);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 6'b100000 || out_cnt !== 2'd1 || out_last !== 1'b1) begin
      n_err++;
      $display("FAIL single_field: valid=%b data=%b cnt=%0d last=%b, required 1 100000 1 1",
               out_valid, out_data, out_cnt, out_last);
    end
    // 01,11 with in_last on the second -> 011100
    drive_cycle(1, 1, 0, 1, o, e);
    drive_cycle(1, 3, 1, 1, o, e);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 6'b011100 || out_cnt !== 2'd2 || out_last !== 1'b1) begin
      n_err++;
      $display("FAIL two_field: valid=%b data=%b cnt=%0d last=%b, required 1 011100 2 1",
               out_valid, out_data, out_cnt, out_last);
    end
    // in_last at the final slot: normal close plus out_last
    drive_cycle(1, 3, 0, 1, o, e);
    drive_cycle(1, 0, 0, 1, o, e);
    drive_cycle(1, 2, 1, 1, o, e);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 6'b110010 || out_cnt !== 2'd3 || out_last !== 1'b1) begin
      n_err++;
      $display("FAIL last_at_end: valid=%b data=%b cnt=%0d last=%b, required 1 110010 3 1",
               out_valid, out_data, out_cnt, out_last);
    end
    drive_cycle(0, 0, 0, 1, o, e);
  endtask

  task automatic test_backpressure();
    logic o; bit e;
    drive_cycle(1, 1, 0, 0, o, e);
    drive_cycle(1, 2, 0, 0, o, e);
    drive_cycle(1, 3, 0, 0, o, e);
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1, c % 4, 0, 0, o, e);
      n_vec++;
      if (o !== 1'b0 || out_valid !== 1'b1 || out_data !== 6'b011011 || out_cnt !== 2'd3 || out_last !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: in_ready=%b valid=%b data=%b cnt=%0d last=%b, required 0 1 011011 3 0",
                 c, o, out_valid, out_data, out_cnt, out_last);
      end
    end
    // Drain and accept a closing field in the same cycle
    drive_cycle(1, 2, 1, 1, o, e);
    n_vec++;
    if (o !== 1'b1 || out_valid !== 1'b1 || out_data !== 6'b100000 || out_cnt !== 2'd1 || out_last !== 1'b1) begin
      n_err++;
      $display("FAIL drain_reload: in_ready=%b valid=%b data=%b cnt=%0d last=%b, required 1 1 100000 1 1",
               o, out_valid, out_data, out_cnt, out_last);
    end
    drive_cycle(0, 0, 0, 1, o, e);
  endtask

  task automatic test_back_to_back();
    logic o; bit e;
    int unsigned d;
    for (int i = 0; i < 9; i++) begin
      d = $urandom_range(0, 3);
      drive_cycle(1, d, 0, 1, o, e);
      n_vec++;
      if (o !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, o);
      end
      if (i % 3 == 2) begin
        n_vec++;
        if (out_valid !== m_valid || out_data !== m_data || out_cnt !== CNT_W'(m_cnt) || out_last !== m_last) begin
          n_err++;
          $display("FAIL b2b_word[%0d]: valid=%b data=%b cnt=%0d last=%b, required %b %b %0d %b",
                   i, out_valid, out_data, out_cnt, out_last, m_valid, m_data, m_cnt, m_last);
        end
      end
    end
    drive_cycle(0, 0, 0, 1, o, e);
  endtask

  task automatic test_random();
    logic o; bit e;
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) != 0, o, e);
      n_vec++;
      if (o !== e || out_valid !== m_valid || out_data !== m_data || out_cnt !== CNT_W'(m_cnt) || out_last !== m_last) begin
        n_err++;
        $display("FAIL random[%0d]: in_ready=%b valid=%b data=%b cnt=%0d last=%b, required %b %b %b %0d %b",
                 i, o, out_valid, out_data, out_cnt, out_last, e, m_valid, m_data, m_cnt, m_last);
      end
`ifdef CONCAT_PACKER_PARITY_EN
      n_vec++;
      if (out_parity !== ^m_data) begin
        n_err++;
        $display("FAIL random_parity[%0d]: got %b required %b", i, out_parity, ^m_data);
      end
`endif
    end
  endtask

  task automatic test_reset_midword();
    logic o; bit e;
    drive_cycle(1, 2, 0, 1, o, e);
    drive_cycle(1, 1, 0, 1, o, e);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_cnt !== '0 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b data=%b cnt=%0d last=%b, required 0 000000 0 0",
               out_valid, out_data, out_cnt, out_last);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    drive_cycle(1, 3, 0, 1, o, e);
    drive_cycle(1, 0, 0, 1, o, e);
    drive_cycle(1, 1, 0, 1, o, e);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 6'b110001 || out_cnt !== 2'd3 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_word: valid=%b data=%b cnt=%0d last=%b, required 1 110001 3 0",
               out_valid, out_data, out_cnt, out_last);
    end
`ifdef CONCAT_PACKER_PARITY_EN
    n_vec++;
    if (out_parity !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_parity: got %b required 1", out_parity);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midword();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
